// File: rtl/sram_copy_engine.sv
// Copy/fill engine driving a single-port SRAM with a one-cycle registered read.
// Copy alternates read/write per word in ascending order; fill writes one word per cycle.
module sram_copy_engine #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          MODE,
  input  logic [AW-1:0] SRC,
  input  logic [AW-1:0] DST,
  input  logic [AW:0]   LEN,
  input  logic [DW-1:0] FILL,
  output logic          BUSY,
  output logic          DONE,
  output logic          MEM_CS,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_A,
  output logic [DW-1:0] MEM_DI,
  input  logic [DW-1:0] MEM_DO
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StFin} state_e;

  localparam logic [AW:0] MaxLen = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] IdxOne = {{AW{1'b0}}, 1'b1};

  state_e        r_state;
  state_e        w_state_next;
  logic          r_mode;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [AW:0]   r_len;
  logic [AW:0]   r_idx;
  logic [DW-1:0] r_fill;

  logic [AW:0]   w_len_sat;
  logic [AW:0]   w_idx_inc;
  logic          w_last;
  logic          w_accept;

  assign w_len_sat = (LEN > MaxLen) ? MaxLen : LEN;
  assign w_idx_inc = r_idx + IdxOne;
  assign w_last    = (w_idx_inc == r_len);
  assign w_accept  = (r_state == StIdle) && START;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (START) begin
          if (w_len_sat == '0) begin
            w_state_next = StFin;
          end else if (MODE) begin
            w_state_next = StWr;
          end else begin
            w_state_next = StRd;
          end
        end
      end
      StRd: w_state_next = StWr;
      StWr: begin
        if (w_last) begin
          w_state_next = StFin;
        end else if (r_mode) begin
          w_state_next = StWr;
        end else begin
          w_state_next = StRd;
        end
      end
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StIdle;
      r_mode  <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_fill  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_mode <= MODE;
        r_src  <= SRC;
        r_dst  <= DST;
        r_len  <= w_len_sat;
        r_fill <= FILL;
        r_idx  <= '0;
      end else if (r_state == StWr) begin
        r_idx <= w_idx_inc;
      end
    end
  end

  // Memory port decodes from registered state only; MEM_DO feeds MEM_DI in copy writes.
  always_comb begin
    BUSY   = (r_state != StIdle);
    DONE   = (r_state == StFin);
    MEM_CS = 1'b0;
    MEM_WE = 1'b0;
    MEM_A  = '0;
    MEM_DI = '0;
    unique case (r_state)
      StRd: begin
        MEM_CS = 1'b1;
        MEM_A  = r_src + r_idx[AW-1:0];
      end
      StWr: begin
        MEM_CS = 1'b1;
        MEM_WE = 1'b1;
        MEM_A  = r_dst + r_idx[AW-1:0];
        MEM_DI = r_mode ? r_fill : MEM_DO;
      end
      default: ;
    endcase
  end

endmodule
